// File: rtl/rv_fetch_aligner.sv
// Halfword instruction queue: reassembles 16/32-bit instructions from aligned fetch blocks.
// Define RV_FETCH_ALIGNER_RVC_EN to decode compressed (16-bit) instructions; otherwise all are 32-bit.
module rv_fetch_aligner #(
  parameter bit          rv64        = 1'b1,
  parameter int          FETCH_WIDTH = 32,
  parameter int          DEPTH       = 8,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        fetch_valid,
  output logic                        fetch_ready,
  input  logic [FETCH_WIDTH-1:0]      fetch_data,
  input  logic                        redirect_valid,
  input  logic [(rv64 ? 64 : 32)-1:0] redirect_pc,
  output logic                        inst_valid,
  input  logic                        inst_ready,
  output logic [31:0]                 inst,
  output logic [(rv64 ? 64 : 32)-1:0] inst_pc,
  output logic                        is_compressed,
  output logic                        inst_illegal
);
  localparam int XLEN = rv64 ? 64 : 32;
  localparam int N    = FETCH_WIDTH / 16;
  localparam int SKW  = $clog2(N);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  logic [15:0]     hw_q [DEPTH];
  logic [15:0]     fetch_hw [N];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [SKW-1:0]  skip_q, skip_d;

  logic [15:0]     h0, h1;
  logic            head_comp, head_illegal, push, pop, head_present;
  logic [CW-1:0]   push_cnt, pop_cnt;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[0];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_split
      assign fetch_hw[gi] = fetch_data[16*gi +: 16];
    end
  endgenerate

  assign h0 = hw_q[rd_ptr_q];
  assign h1 = hw_q[rd_ptr_q + PW'(1)];

  always_comb begin
`ifdef RV_FETCH_ALIGNER_RVC_EN
    head_comp    = (h0[1:0] != 2'b11);
    head_illegal = (h0 == 16'h0000);
`else
    head_comp    = 1'b0;
    head_illegal = (h0[1:0] != 2'b11) || (h0 == 16'h0000);
`endif
  end

  // Flags are qualified by a non-empty queue so stale storage never leaks out.
  assign head_present  = (count_q != '0);
  assign is_compressed = head_comp && head_present;
  assign inst_illegal  = head_illegal && head_present;
  assign inst_valid    = (count_q >= CW'(2)) || (head_comp && head_present);
  assign inst          = head_comp ? {16'h0000, h0} : {h1, h0};
  assign inst_pc       = pc_q;
  assign fetch_ready   = (CW'(DEPTH) - count_q) >= CW'(N);

  assign push     = fetch_valid && fetch_ready && !redirect_valid;
  assign pop      = inst_valid && inst_ready && !redirect_valid;
  assign push_cnt = CW'(N) - CW'(skip_q);
  assign pop_cnt  = head_comp ? CW'(1) : CW'(2);

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    pc_d     = pc_q;
    skip_d   = skip_q;
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      pc_d     = {redirect_pc[XLEN-1:1], 1'b0};
      skip_d   = redirect_pc[SKW:1];
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(push_cnt);
        skip_d   = '0;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
        pc_d     = pc_q + XLEN'({pop_cnt, 1'b0});
      end
      count_d = count_q + (push ? push_cnt : '0) - (pop ? pop_cnt : '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      pc_q     <= RESET_PC[XLEN-1:0];
      skip_q   <= RESET_PC[SKW:1];
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      pc_q     <= pc_d;
      skip_q   <= skip_d;
    end
  end

  // Halfwords below the entry PC of the first block are never stored.
  always_ff @(posedge clock) begin
    if (push) begin
      for (int i = 0; i < N; i++) begin
        if (i >= int'(skip_q)) begin
          hw_q[wr_ptr_q + PW'(i) - PW'(skip_q)] <= fetch_hw[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_rv_fetch_aligner.sv
// Directed bench for rv_fetch_aligner: a 32-bit-fetch instance and a 64-bit-fetch instance.
// Expected values adapt to whether RV_FETCH_ALIGNER_RVC_EN is defined.
module tb_rv_fetch_aligner;
`ifdef RV_FETCH_ALIGNER_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        fetch_valid, redirect_valid, inst_ready;
  logic [31:0] fetch_data;
  logic [63:0] redirect_pc;
  logic        fetch_ready, inst_valid, is_compressed, inst_illegal;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  logic        fetch_valid_w, redirect_valid_w, inst_ready_w;
  logic [63:0] fetch_data_w;
  logic [63:0] redirect_pc_w;
  logic        fetch_ready_w, inst_valid_w, is_compressed_w, inst_illegal_w;
  logic [31:0] inst_w;
  logic [63:0] inst_pc_w;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] fill_tbl [5];

  always #5 clock = ~clock;

  rv_fetch_aligner #(.rv64(1'b1), .FETCH_WIDTH(32), .DEPTH(8), .RESET_PC(64'h0)) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .is_compressed(is_compressed), .inst_illegal(inst_illegal)
  );

  rv_fetch_aligner #(.rv64(1'b1), .FETCH_WIDTH(64), .DEPTH(8), .RESET_PC(64'h0)) dut_w (
    .clock(clock), .reset_n(reset_n),
    .fetch_valid(fetch_valid_w), .fetch_ready(fetch_ready_w), .fetch_data(fetch_data_w),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
    .inst_valid(inst_valid_w), .inst_ready(inst_ready_w), .inst(inst_w), .inst_pc(inst_pc_w),
    .is_compressed(is_compressed_w), .inst_illegal(inst_illegal_w)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    fetch_valid = 1'b0; fetch_data = '0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    fetch_valid_w = 1'b0; fetch_data_w = '0; redirect_valid_w = 1'b0; redirect_pc_w = '0; inst_ready_w = 1'b0;
    fill_tbl = '{32'h00A10013, 32'h00A20013, 32'h00A30013, 32'h00A40013, 32'h00A50013};
    tick(); tick();
    chk("rst_fetch_ready", fetch_ready, 1);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_is_compressed", is_compressed, 0);
    chk("rst_inst_illegal", inst_illegal, 0);
    chk("rst_inst_pc", inst_pc, 0);
    reset_n = 1'b1;

    // First block: one-cycle latency, mode-dependent head decode
    fetch_valid = 1'b1; fetch_data = 32'h00130001; tick(); fetch_valid = 1'b0;
    chk("s1_valid", inst_valid, 1);
    chk("s1_inst", inst, RVC ? 64'h00000001 : 64'h00130001);
    chk("s1_pc", inst_pc, 0);
    chk("s1_comp", is_compressed, RVC ? 64'h1 : 64'h0);
    chk("s1_illegal", inst_illegal, RVC ? 64'h0 : 64'h1);
    chk("s1_fready", fetch_ready, 1);
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    chk("s1_pop_pc", inst_pc, RVC ? 64'h2 : 64'h4);
    chk("s1_pop_valid", inst_valid, 0);
    fetch_valid = 1'b1; fetch_data = 32'h00B70093; tick(); fetch_valid = 1'b0;
    chk("s1_str_valid", inst_valid, 1);
    chk("s1_str_inst", inst, RVC ? 64'h00930013 : 64'h00B70093);
    chk("s1_str_pc", inst_pc, RVC ? 64'h2 : 64'h4);
    chk("s1_str_comp", is_compressed, 0);

    redirect_valid = 1'b1; redirect_pc = 64'h0; tick(); redirect_valid = 1'b0;
    chk("rd0_valid", inst_valid, 0);
    chk("rd0_pc", inst_pc, 0);
    chk("rd0_fready", fetch_ready, 1);

    // Fill to capacity, offer one extra block, then drain
    fetch_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill%0d_fready", k), fetch_ready, 1);
      fetch_data = fill_tbl[k];
      tick();
    end
    fetch_data = fill_tbl[4];
    chk("full_fready", fetch_ready, 0);
    tick();
    chk("full_hold_fready", fetch_ready, 0);
    chk("full_head", inst, fill_tbl[0]);
    fetch_valid = 1'b0; inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_valid", k), inst_valid, 1);
      chk($sformatf("drain%0d_inst", k), inst, fill_tbl[k]);
      chk($sformatf("drain%0d_pc", k), inst_pc, 64'(4 * k));
      tick();
    end
    inst_ready = 1'b0;
    chk("drain_empty", inst_valid, 0);
    chk("drain_pc", inst_pc, 64'd16);

    // Push and pop in the same cycle
    fetch_valid = 1'b1; fetch_data = fill_tbl[0]; tick();
    fetch_data = fill_tbl[1]; inst_ready = 1'b1; tick();
    fetch_valid = 1'b0; inst_ready = 1'b0;
    chk("pp_valid", inst_valid, 1);
    chk("pp_inst", inst, fill_tbl[1]);
    chk("pp_pc", inst_pc, 64'd20);
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    chk("pp_empty", inst_valid, 0);
    chk("pp_pc2", inst_pc, 64'd24);

    // Redirect beats push and pop; new PC skips one halfword
    fetch_valid = 1'b1; fetch_data = fill_tbl[2]; tick();
    fetch_data = 32'hDEADBEEF; redirect_valid = 1'b1; redirect_pc = 64'h0000_0001_0000_0043;
    inst_ready = 1'b1; tick();
    fetch_valid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    chk("rr_valid", inst_valid, 0);
    chk("rr_pc", inst_pc, 64'h0000_0001_0000_0042);
    chk("rr_fready", fetch_ready, 1);
    fetch_valid = 1'b1; fetch_data = 32'h00A70013; tick();
    chk("sk_stall", inst_valid, 0);
    fetch_data = 32'h55550017; tick(); fetch_valid = 1'b0;
    chk("sk_valid", inst_valid, 1);
    chk("sk_inst", inst, 64'h001700A7);
    chk("sk_pc", inst_pc, 64'h0000_0001_0000_0042);

    // Illegal encodings
    redirect_valid = 1'b1; redirect_pc = 64'h0; tick(); redirect_valid = 1'b0;
    fetch_valid = 1'b1; fetch_data = 32'h00000000; tick(); fetch_valid = 1'b0;
    chk("ill0_valid", inst_valid, 1);
    chk("ill0_illegal", inst_illegal, 1);
    chk("ill0_comp", is_compressed, RVC ? 64'h1 : 64'h0);
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    chk("ill0_pop_pc", inst_pc, RVC ? 64'h2 : 64'h4);
    redirect_valid = 1'b1; redirect_pc = 64'h0; tick(); redirect_valid = 1'b0;
    fetch_valid = 1'b1; fetch_data = 32'h00134501; tick(); fetch_valid = 1'b0;
    chk("c_inst", inst, RVC ? 64'h00004501 : 64'h00134501);
    chk("c_illegal", inst_illegal, RVC ? 64'h0 : 64'h1);
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    chk("c_pop_pc", inst_pc, RVC ? 64'h2 : 64'h4);

    // 64-bit fetch: redirect to 0x106 drops three halfwords of the 0x100 block
    redirect_valid_w = 1'b1; redirect_pc_w = 64'h106; tick(); redirect_valid_w = 1'b0;
    chk("w_rd_valid", inst_valid_w, 0);
    chk("w_rd_pc", inst_pc_w, 64'h106);
    fetch_valid_w = 1'b1; fetch_data_w = 64'h0513_AAAA_BBBB_CCCC; tick();
    chk("w_sk_stall", inst_valid_w, 0);
    chk("w_sk_fready", fetch_ready_w, 1);
    fetch_data_w = 64'h0033_0022_0011_0005; tick(); fetch_valid_w = 1'b0;
    chk("w_valid", inst_valid_w, 1);
    chk("w_inst", inst_w, 64'h00050513);
    chk("w_pc", inst_pc_w, 64'h106);
    chk("w_fready", fetch_ready_w, 0);
    inst_ready_w = 1'b1; tick(); inst_ready_w = 1'b0;
    chk("w_pop_pc", inst_pc_w, 64'h10A);
    chk("w_pop_valid", inst_valid_w, 1);
    chk("w_pop_fready", fetch_ready_w, 1);

    // Asynchronous reset empties the queue without a clock edge
    reset_n = 1'b0; #2;
    chk("ar_valid_w", inst_valid_w, 0);
    chk("ar_fready_w", fetch_ready_w, 1);
    chk("ar_pc", inst_pc, 0);
    chk("ar_valid", inst_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
